mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory with latency-modelled read and write request channels
// and a backdoor host port. Each channel runs an IDLE/WAIT/READY handshake FSM.
module mem_responder #(
  parameter int AW      = 5,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read_enable,
  input  logic [63:0]   read_addr,
  input  logic [63:0]   read_size,
  input  logic          finish_read,
  output logic [63:0]   read_ready,
  output logic [31:0]   read_data,
  input  logic          write_enable,
  input  logic [63:0]   write_addr,
  input  logic [31:0]   write_data,
  input  logic [63:0]   write_size,
  input  logic          finish_write,
  output logic [63:0]   write_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  output logic [31:0]   host_rdata,
  output logic [31:0]   rd_beats,
  output logic [31:0]   wr_beats,
  output logic [15:0]   err_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [31:0] mem [0:(1<<AW)-1];

  state_t      rd_state, rd_next, wr_state, wr_next;
  logic [3:0]  rd_cnt, rd_cnt_next, wr_cnt, wr_cnt_next;
  logic        rd_fire, wr_fire, rd_stray, wr_stray;
  logic        rd_bad, wr_bad, wr_commit, host_commit, host_drop;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [2:0]  err_inc;
  logic [16:0] err_sum;

  function automatic logic addr_bad(input logic [63:0] a);
    return (a[63:AW+2] != '0) || (a[1:0] != 2'b00);
  endfunction

  always_comb begin
    rd_next     = rd_state;
    rd_cnt_next = rd_cnt;
    rd_fire     = 1'b0;
    rd_stray    = finish_read && (rd_state != READY);
    case (rd_state)
      IDLE: if (read_enable) begin
        rd_next     = WAIT;
        rd_cnt_next = LAT_M1;
      end
      WAIT: begin
        if (!read_enable)      rd_next = IDLE;
        else if (rd_cnt != 0)  rd_cnt_next = rd_cnt - 4'd1;
        else begin
          rd_next = READY;
          rd_fire = 1'b1;
        end
      end
      READY: begin
        // Dropping enable wins over a simultaneous finish pulse.
        if (!read_enable) rd_next = IDLE;
        else if (finish_read) begin
          rd_next     = WAIT;
          rd_cnt_next = LAT_M1;
        end
      end
      default: rd_next = IDLE;
    endcase
  end

  always_comb begin
    wr_next     = wr_state;
    wr_cnt_next = wr_cnt;
    wr_fire     = 1'b0;
    wr_stray    = finish_write && (wr_state != READY);
    case (wr_state)
      IDLE: if (write_enable) begin
        wr_next     = WAIT;
        wr_cnt_next = LAT_M1;
      end
      WAIT: begin
        if (!write_enable)     wr_next = IDLE;
        else if (wr_cnt != 0)  wr_cnt_next = wr_cnt - 4'd1;
        else begin
          wr_next = READY;
          wr_fire = 1'b1;
        end
      end
      READY: begin
        if (!write_enable) wr_next = IDLE;
        else if (finish_write) begin
          wr_next     = WAIT;
          wr_cnt_next = LAT_M1;
        end
      end
      default: wr_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= IDLE;
      wr_state <= IDLE;
      rd_cnt   <= 4'd0;
      wr_cnt   <= 4'd0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      rd_cnt   <= rd_cnt_next;
      wr_cnt   <= wr_cnt_next;
    end
  end

  assign rd_bad      = addr_bad(read_addr);
  assign wr_bad      = addr_bad(write_addr);
  assign rd_idx      = read_addr[AW+1:2];
  assign wr_idx      = write_addr[AW+1:2];
  assign wr_commit   = wr_fire && !wr_bad;
  assign host_commit = host_we && (wr_state == IDLE);
  assign host_drop   = host_we && (wr_state != IDLE);

  assign err_inc = 3'(rd_fire && rd_bad) + 3'(rd_fire && (read_size != 64'd4))
                 + 3'(wr_fire && wr_bad) + 3'(wr_fire && (write_size != 64'd4))
                 + 3'(rd_stray) + 3'(wr_stray) + 3'(host_drop);
  assign err_sum = {1'b0, err_cnt} + {14'd0, err_inc};

  // Memory has no reset; gating on reset keeps an aborted commit out of the array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_commit)        mem[wr_idx]    <= write_data;
      else if (host_commit) mem[host_addr] <= host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= 32'd0;
      host_rdata <= 32'd0;
      rd_beats   <= 32'd0;
      wr_beats   <= 32'd0;
      err_cnt    <= 16'd0;
    end else begin
      if (rd_fire) read_data <= rd_bad ? 32'hDEADBEEF : mem[rd_idx];
      host_rdata <= mem[host_addr];
      if (rd_fire && (rd_beats != '1)) rd_beats <= rd_beats + 32'd1;
      if (wr_fire && (wr_beats != '1)) wr_beats <= wr_beats + 32'd1;
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign read_ready  = {63'd0, rd_state == READY};
  assign write_ready = {63'd0, wr_state == READY};

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized single beats checked
// against an array-based memory model and expected counters.
module tb_mem_responder;
  localparam int AW = 5;
  localparam int LATENCY = 2;
  localparam int WORDS = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_enable, finish_read, write_enable, finish_write, host_we;
  logic [63:0]   read_addr, read_size, write_addr, write_size;
  logic [31:0]   write_data, host_wdata;
  logic [AW-1:0] host_addr;
  logic [63:0]   read_ready, write_ready;
  logic [31:0]   read_data, host_rdata, rd_beats, wr_beats;
  logic [15:0]   err_cnt;

  mem_responder #(.AW(AW), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
    .finish_read(finish_read), .read_ready(read_ready), .read_data(read_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .write_size(write_size), .finish_write(finish_write), .write_ready(write_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .rd_beats(rd_beats), .wr_beats(wr_beats), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mdl [WORDS];
  int exp_rd = 0, exp_wr = 0, exp_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [63:0] a);
    return (a < 64'(WORDS * 4)) && (a % 64'd4 == 64'd0);
  endfunction

  task automatic wait_rd(output bit ok, output int n);
    ok = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      step(); n++;
      if (read_ready == 64'd1) begin ok = 1; break; end
    end
  endtask

  task automatic wait_wr(output bit ok, output int n);
    ok = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      step(); n++;
      if (write_ready == 64'd1) begin ok = 1; break; end
    end
  endtask

  task automatic host_write(input int idx, input logic [31:0] v);
    host_we = 1; host_addr = AW'(idx); host_wdata = v;
    step();
    host_we = 0;
    mdl[idx] = v;
  endtask

  task automatic host_read(input int idx, output logic [31:0] v);
    host_addr = AW'(idx);
    step();
    v = host_rdata;
  endtask

  task automatic idle_inputs();
    read_enable = 0; finish_read = 0; write_enable = 0; finish_write = 0; host_we = 0;
    read_addr = 0; read_size = 4; write_addr = 0; write_size = 4; write_data = 0;
    host_addr = 0; host_wdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    n_checks++; if (read_ready !== 64'd0) begin n_fail++; $display("FAIL reset_read_ready: got %0h expected 0", read_ready); end
    n_checks++; if (write_ready !== 64'd0) begin n_fail++; $display("FAIL reset_write_ready: got %0h expected 0", write_ready); end
    n_checks++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL reset_read_data: got %0h expected 0", read_data); end
    n_checks++; if (host_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_host_rdata: got %0h expected 0", host_rdata); end
    n_checks++; if ({rd_beats, wr_beats, err_cnt} !== 80'd0) begin n_fail++; $display("FAIL reset_counters: got %0h/%0h/%0h expected 0/0/0", rd_beats, wr_beats, err_cnt); end
    reset = 0;
    step();
    for (int i = 0; i < WORDS; i++) host_write(i, $urandom);
    for (int i = 0; i < 4; i++) host_write(i, 32'(i + 1));
  endtask

  task automatic test_read_burst();
    bit ok; int n; logic [31:0] held;
    read_enable = 1; read_addr = 0; read_size = 4;
    step();
    n_checks++; if (read_ready !== 64'd0) begin n_fail++; $display("FAIL rd_early_ready: got %0h expected 0", read_ready); end
    for (int b = 0; b < 4; b++) begin
      wait_rd(ok, n);
      n_checks++; if (!ok || n != LATENCY) begin n_fail++; $display("FAIL rd_latency beat %0d: got %0d cycles (ok=%0d) expected %0d", b, n, ok, LATENCY); end
      exp_rd++;
      n_checks++; if (read_data !== 32'(b + 1)) begin n_fail++; $display("FAIL rd_burst_data beat %0d: got %0h expected %0h", b, read_data, b + 1); end
      held = read_data;
      step();
      n_checks++; if (read_ready !== 64'd1 || read_data !== held) begin n_fail++; $display("FAIL rd_hold beat %0d: got ready %0h data %0h expected 1 %0h", b, read_ready, read_data, held); end
      if (b < 3) begin
        finish_read = 1; read_addr = 64'(4 * (b + 1));
        step();
        finish_read = 0;
        n_checks++; if (read_ready !== 64'd0) begin n_fail++; $display("FAIL rd_finish_drop: got %0h expected 0", read_ready); end
      end
    end
    read_enable = 0;
    step();
    n_checks++; if (rd_beats !== 32'(exp_rd) || err_cnt !== 16'(exp_err)) begin n_fail++; $display("FAIL rd_burst_counts: got %0d/%0d expected %0d/%0d", rd_beats, err_cnt, exp_rd, exp_err); end
  endtask

  task automatic test_write_burst();
    bit ok; int n; int pulses; logic [31:0] v;
    pulses = 0;
    write_enable = 1; write_addr = 64'h10; write_data = 32'hA; write_size = 4;
    step();
    for (int b = 0; b < 3; b++) begin
      wait_wr(ok, n);
      n_checks++; if (!ok || n != LATENCY) begin n_fail++; $display("FAIL wr_latency beat %0d: got %0d cycles (ok=%0d) expected %0d", b, n, ok, LATENCY); end
      if (ok) pulses++;
      mdl[4 + b] = 32'hA + 32'(b);
      exp_wr++;
      if (b < 2) begin
        finish_write = 1; write_addr = write_addr + 64'd4; write_data = write_data + 32'd1;
        step();
        finish_write = 0;
      end else begin
        write_enable = 0;
        step();
      end
      n_checks++; if (write_ready !== 64'd0) begin n_fail++; $display("FAIL wr_ready_drop beat %0d: got %0h expected 0", b, write_ready); end
    end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL wr_pulses: got %0d expected 3", pulses); end
    for (int i = 4; i < 7; i++) begin
      host_read(i, v);
      n_checks++; if (v !== 32'hA + 32'(i - 4)) begin n_fail++; $display("FAIL wr_host_readback word %0d: got %0h expected %0h", i, v, 32'hA + 32'(i - 4)); end
    end
    n_checks++; if (wr_beats !== 32'(exp_wr)) begin n_fail++; $display("FAIL wr_beats: got %0d expected %0d", wr_beats, exp_wr); end
  endtask

  task automatic test_abort_and_bad_addr();
    bit ok; int n; bit seen;
    seen = 0;
    read_enable = 1; read_addr = 0;
    step();
    read_enable = 0;
    for (int i = 0; i < 5; i++) begin step(); if (read_ready !== 64'd0) seen = 1; end
    n_checks++; if (seen || rd_beats !== 32'(exp_rd)) begin n_fail++; $display("FAIL rd_abort: got seen_ready %0d beats %0d expected 0 %0d", seen, rd_beats, exp_rd); end
    read_enable = 1; read_addr = 64'h80;
    step();
    wait_rd(ok, n);
    exp_rd++; exp_err++;
    n_checks++; if (!ok || read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_bad_addr: got %0h (ok=%0d) expected deadbeef", read_data, ok); end
    read_enable = 0;
    step();
    n_checks++; if (err_cnt !== 16'(exp_err) || rd_beats !== 32'(exp_rd)) begin n_fail++; $display("FAIL rd_bad_counts: got err %0d beats %0d expected %0d %0d", err_cnt, rd_beats, exp_err, exp_rd); end
  endtask

  task automatic test_finish_with_drop();
    bit ok; int n; bit seen;
    seen = 0;
    read_enable = 1; read_addr = 64'h8;
    step();
    wait_rd(ok, n);
    exp_rd++;
    n_checks++; if (!ok || read_data !== mdl[2]) begin n_fail++; $display("FAIL drop_data: got %0h (ok=%0d) expected %0h", read_data, ok, mdl[2]); end
    finish_read = 1; read_enable = 0;
    step();
    finish_read = 0;
    if (read_ready !== 64'd0) seen = 1;
    for (int i = 0; i < 4; i++) begin step(); if (read_ready !== 64'd0) seen = 1; end
    n_checks++; if (seen || rd_beats !== 32'(exp_rd) || err_cnt !== 16'(exp_err)) begin n_fail++; $display("FAIL drop_dominates: got seen %0d beats %0d err %0d expected 0 %0d %0d", seen, rd_beats, err_cnt, exp_rd, exp_err); end
  endtask

  task automatic test_stray_finish();
    finish_read = 1; step(); finish_read = 0; exp_err++;
    finish_write = 1; step(); finish_write = 0; exp_err++;
    finish_read = 1; finish_write = 1; step(); finish_read = 0; finish_write = 0; exp_err += 2;
    step();
    n_checks++; if (err_cnt !== 16'(exp_err)) begin n_fail++; $display("FAIL stray_finish: got %0d expected %0d", err_cnt, exp_err); end
  endtask

  task automatic test_read_before_write();
    bit ok; int n; logic [31:0] oldv, newv, v;
    oldv = mdl[7]; newv = ~oldv;
    read_enable = 1; read_addr = 64'h1C; write_enable = 1; write_addr = 64'h1C; write_data = newv;
    step();
    wait_rd(ok, n);
    exp_rd++; exp_wr++; mdl[7] = newv;
    n_checks++; if (!ok || read_data !== oldv || write_ready !== 64'd1) begin n_fail++; $display("FAIL rbw: got data %0h wready %0h expected %0h 1", read_data, write_ready, oldv); end
    read_enable = 0; write_enable = 0;
    step();
    host_read(7, v);
    n_checks++; if (v !== newv) begin n_fail++; $display("FAIL rbw_commit: got %0h expected %0h", v, newv); end
  endtask

  task automatic test_host_we_busy();
    bit ok; int n; logic [31:0] v, d;
    d = $urandom;
    write_enable = 1; write_addr = 64'h40; write_data = d;
    step();
    host_we = 1; host_addr = 3; host_wdata = ~mdl[3];
    step();
    host_we = 0; exp_err++;
    wait_wr(ok, n);
    mdl[16] = d; exp_wr++;
    write_enable = 0;
    step();
    host_read(3, v);
    n_checks++; if (v !== mdl[3]) begin n_fail++; $display("FAIL host_busy_drop: got %0h expected %0h", v, mdl[3]); end
    host_read(16, v);
    n_checks++; if (!ok || v !== d) begin n_fail++; $display("FAIL host_busy_burst: got %0h (ok=%0d) expected %0h", v, ok, d); end
    n_checks++; if (err_cnt !== 16'(exp_err)) begin n_fail++; $display("FAIL host_busy_err: got %0d expected %0d", err_cnt, exp_err); end
  endtask

  task automatic test_random();
    bit ok; int n; int r; bit is_rd; int bad_words;
    logic [63:0] a, sz; logic [31:0] d, v, expv;
    logic [63:0] bad_sizes [4];
    bad_sizes[0] = 64'd1; bad_sizes[1] = 64'd8; bad_sizes[2] = 64'd0; bad_sizes[3] = 64'h1_0000_0004;
    for (int it = 0; it < 60; it++) begin
      is_rd = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      if (r < 7)       a = 64'($urandom_range(0, WORDS - 1)) * 4;
      else if (r == 7) a = 64'($urandom_range(0, WORDS - 1)) * 4 + 64'($urandom_range(1, 3));
      else if (r == 8) a = 64'h80 + 64'($urandom_range(0, 63)) * 4;
      else             a = (64'd1 << $urandom_range(8, 63)) + 64'($urandom_range(0, WORDS - 1)) * 4;
      sz = ($urandom_range(0, 3) == 0) ? bad_sizes[$urandom_range(0, 3)] : 64'd4;
      d = $urandom;
      if (is_rd) begin
        read_enable = 1; read_addr = a; read_size = sz;
      end else begin
        write_enable = 1; write_addr = a; write_size = sz; write_data = d;
      end
      step();
      if (is_rd) wait_rd(ok, n); else wait_wr(ok, n);
      n_checks++; if (!ok || n != LATENCY) begin n_fail++; $display("FAIL rand_latency it %0d: got %0d cycles (ok=%0d) expected %0d", it, n, ok, LATENCY); end
      if (!legal(a)) exp_err++;
      if (sz != 64'd4) exp_err++;
      if (is_rd) begin
        exp_rd++;
        expv = legal(a) ? mdl[a / 4] : 32'hDEADBEEF;
        n_checks++; if (read_data !== expv) begin n_fail++; $display("FAIL rand_read it %0d addr %0h: got %0h expected %0h", it, a, read_data, expv); end
      end else begin
        exp_wr++;
        if (legal(a)) mdl[a / 4] = d;
      end
      read_enable = 0; write_enable = 0; read_size = 4; write_size = 4;
      step();
      n_checks++; if (err_cnt !== 16'(exp_err) || rd_beats !== 32'(exp_rd) || wr_beats !== 32'(exp_wr)) begin
        n_fail++; $display("FAIL rand_counts it %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", it, err_cnt, rd_beats, wr_beats, exp_err, exp_rd, exp_wr);
      end
    end
    bad_words = 0;
    for (int i = 0; i < WORDS; i++) begin host_read(i, v); if (v !== mdl[i]) bad_words++; end
    n_checks++; if (bad_words != 0) begin n_fail++; $display("FAIL rand_mem_image: got %0d differing words expected 0", bad_words); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] v;
    host_write(2, 32'h55);
    write_enable = 1; write_addr = 64'h8; write_data = 32'h99;
    step(); step();
    reset = 1;
    step();
    n_checks++; if (read_ready !== 64'd0 || write_ready !== 64'd0) begin n_fail++; $display("FAIL rst_mid_ready: got %0h/%0h expected 0/0", read_ready, write_ready); end
    n_checks++; if (read_data !== 32'd0 || host_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_mid_data: got %0h/%0h expected 0/0", read_data, host_rdata); end
    n_checks++; if ({rd_beats, wr_beats, err_cnt} !== 80'd0) begin n_fail++; $display("FAIL rst_mid_counters: got %0h/%0h/%0h expected 0/0/0", rd_beats, wr_beats, err_cnt); end
    reset = 0; write_enable = 0;
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    step();
    host_read(2, v);
    n_checks++; if (v !== 32'h55 || write_ready !== 64'd0 || wr_beats !== 32'd0) begin n_fail++; $display("FAIL rst_no_commit: got %0h ready %0h beats %0d expected 55 0 0", v, write_ready, wr_beats); end
  endtask

  task automatic test_saturation();
    finish_read = 1; finish_write = 1;
    repeat (32800) step();
    finish_read = 0; finish_write = 0;
    exp_err = (exp_err + 2 * 32800 > 65535) ? 65535 : exp_err + 2 * 32800;
    step();
    n_checks++; if (err_cnt !== 16'(exp_err)) begin n_fail++; $display("FAIL err_saturate: got %0h expected %0h", err_cnt, exp_err); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_burst();
    test_write_burst();
    test_abort_and_bad_addr();
    test_finish_with_drop();
    test_stray_finish();
    test_read_before_write();
    test_host_we_busy();
    test_random();
    test_reset_mid_write();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
